// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, redirect-kind encoding and the branch-target
// helper used by the instruction fetch stage of the MIPS core.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2
    } redir_kind_e;

    // Branch target: address of the instruction after the branch plus the
    // signed word offset, wrapping modulo 2^32.
    function automatic logic [XLEN-1:0] branch_target(
        input logic [XLEN-1:0] base_pc,
        input logic [XLEN-1:0] word_offset
    );
        branch_target = base_pc + XLEN'(INSTR_BYTES) + {word_offset[XLEN-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_imem.sv
// fetch_imem: on-chip instruction memory with one synchronous write port
// (loader side) and one asynchronous read port (fetch side).
// The array is never reset, so a program loaded during reset survives it.
module fetch_imem
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [XLEN-1:0]   rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [XLEN-1:0] mem [DEPTH];

    // Loader write; a same-cycle read of this index still sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction memory and registered fetch output towards
// decode, with jump/branch redirect, flush and a sticky misaligned-jump fault.
// Optional build macro FETCH_DIV_EN: fetches only every DIV-th cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 5,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0,
    parameter int              DIV      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [XLEN-1:0]   imem_wdata,
    input  logic              redir_jump,
    input  logic [XLEN-1:0]   redir_target,
    input  logic              redir_branch,
    input  logic [XLEN-1:0]   redir_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic              fault
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] mem_rdata;
    logic            step;
    redir_kind_e     redir_kind;

    fetch_imem #(
        .ADDR_W (ADDR_W)
    ) u_imem (
        .clk    (clk),
        .we     (imem_we),
        .waddr  (imem_waddr),
        .wdata  (imem_wdata),
        .raddr  (pc_q[ADDR_W+1:2]),
        .rdata  (mem_rdata)
    );

`ifdef FETCH_DIV_EN
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

    // Free-running divider 0..DIV-1; a fetch is allowed only on its last count.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_cnt_q == DIV_W'(DIV - 1)) begin
            div_cnt_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign step = (div_cnt_q == DIV_W'(DIV - 1));
`else
    // DIV is always a legal ratio (>= 1), so this is a constant 1.
    assign step = (DIV >= 1);
`endif

    // Jump beats branch; both override any fetch.
    always_comb begin
        redir_kind = NONE;
        if (redir_jump) begin
            redir_kind = JUMP;
        end else if (redir_branch) begin
            redir_kind = BRANCH;
        end
    end

    // Next-state for PC, output register and fault.
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        fault_d     = fault_q;
        case (redir_kind)
            JUMP: begin
                pc_d        = {redir_target[XLEN-1:2], 2'b00};
                out_valid_d = 1'b0;
                if (redir_target[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                end
            end
            BRANCH: begin
                pc_d        = branch_target(out_pc_q, redir_offset);
                out_valid_d = 1'b0;
            end
            default: begin
                if (step && (!out_valid_q || out_ready)) begin
                    out_instr_d = mem_rdata;
                    out_pc_d    = pc_q;
                    out_valid_d = 1'b1;
                    pc_d        = pc_q + XLEN'(INSTR_BYTES);
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State registers; reset overrides any stall or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            fault_q     <= fault_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign fault     = fault_q;

endmodule
